// File: rtl/switch_allocator.sv
// Per-output wormhole switch allocator: round-robin among head flits, with the
// output locked to its owner from head to tail so packets never interleave.
module switch_allocator #(
  parameter int N_IN  = 5,
  parameter int N_OUT = 5,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic [N_IN-1:0]          req_valid_i,
  input  logic [N_IN*N_OUT-1:0]    req_port_i,
  input  logic [N_IN*2-1:0]        req_type_i,
  input  logic [N_OUT-1:0]         out_ready_i,
  output logic [N_OUT*N_IN-1:0]    grant_o,
  output logic [N_OUT-1:0]         out_valid_o,
  output logic [N_IN-1:0]          in_ready_o,
  output logic [N_OUT-1:0]         lock_o,
  output logic [N_IN-1:0]          err_o,
  output logic [N_OUT*CNT_W-1:0]   pkt_cnt_o
);

  localparam int PTR_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam logic [1:0] TY_HEAD = 2'b00;
  localparam logic [1:0] TY_BODY = 2'b01;
  localparam logic [1:0] TY_TAIL = 2'b10;
  localparam logic [1:0] TY_HT   = 2'b11;

  localparam logic [PTR_W-1:0] RR_RESET = PTR_W'(N_IN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Wrap-around successor used by the round-robin search.
  function automatic logic [PTR_W-1:0] rrNext(input logic [PTR_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_IN) s = s - N_IN;
    return PTR_W'(s);
  endfunction

  logic [N_OUT-1:0] reqPort [N_IN];
  logic [1:0]       reqType [N_IN];
  logic [N_IN-1:0]  portOk;
  logic [N_IN-1:0]  isStart;
  logic [N_IN-1:0]  isCont;
  logic [N_IN-1:0]  elig [N_OUT];

  logic [0:0]       state_q [N_OUT];
  logic [0:0]       state_d [N_OUT];
  logic [PTR_W-1:0] owner_q [N_OUT];
  logic [PTR_W-1:0] owner_d [N_OUT];
  logic [PTR_W-1:0] rr_q    [N_OUT];
  logic [PTR_W-1:0] rr_d    [N_OUT];
  logic [CNT_W-1:0] cnt_q   [N_OUT];
  logic [CNT_W-1:0] cnt_d   [N_OUT];
  logic [N_IN-1:0]  err_q;
  logic [N_IN-1:0]  err_d;

  logic [N_IN-1:0]  grant   [N_OUT];
  logic [PTR_W-1:0] winIdx  [N_OUT];
  logic [1:0]       winType [N_OUT];
  logic [N_OUT-1:0] winFound;
  logic [N_OUT-1:0] xfer;
  logic [N_IN-1:0]  ownsPort;
  logic [N_IN-1:0]  errSet;

  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      reqPort[i] = req_port_i[i*N_OUT +: N_OUT];
      reqType[i] = req_type_i[i*2 +: 2];
      portOk[i]  = $onehot(reqPort[i]);
      isStart[i] = (reqType[i] == TY_HEAD) || (reqType[i] == TY_HT);
      isCont[i]  = (reqType[i] == TY_BODY) || (reqType[i] == TY_TAIL);
    end
    for (int o = 0; o < N_OUT; o++) begin
      for (int i = 0; i < N_IN; i++) begin
        elig[o][i] = req_valid_i[i] & portOk[i] & reqPort[i][o] & isStart[i];
      end
    end
  end

  // A locked output only ever serves its owner; grants are suppressed during reset.
  always_comb begin
    for (int o = 0; o < N_OUT; o++) begin
      grant[o]    = '0;
      winIdx[o]   = owner_q[o];
      winFound[o] = 1'b0;
      if (state_q[o] == ST_IDLE) begin
        for (int k = 1; k <= N_IN; k++) begin
          if (!winFound[o] && elig[o][rrNext(rr_q[o], k)]) begin
            winIdx[o]   = rrNext(rr_q[o], k);
            winFound[o] = 1'b1;
          end
        end
      end else begin
        winFound[o] = req_valid_i[owner_q[o]] & reqPort[owner_q[o]][o];
      end
      winType[o] = reqType[winIdx[o]];
      if (winFound[o] && !arst) grant[o][winIdx[o]] = 1'b1;
    end
  end

  always_comb begin
    for (int o = 0; o < N_OUT; o++) begin
      grant_o[o*N_IN +: N_IN]    = grant[o];
      out_valid_o[o]             = |grant[o];
      xfer[o]                    = out_valid_o[o] & out_ready_i[o];
      lock_o[o]                  = (state_q[o] == ST_LOCKED);
      pkt_cnt_o[o*CNT_W +: CNT_W] = cnt_q[o];
    end
    for (int i = 0; i < N_IN; i++) begin
      in_ready_o[i] = 1'b0;
      for (int o = 0; o < N_OUT; o++) begin
        in_ready_o[i] = in_ready_o[i] | (grant[o][i] & out_ready_i[o]);
      end
    end
  end

  // Body/tail flits are legal only from the owner of a locked output they target.
  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      ownsPort[i] = 1'b0;
      for (int o = 0; o < N_OUT; o++) begin
        if ((state_q[o] == ST_LOCKED) && (owner_q[o] == PTR_W'(i)) && reqPort[i][o]) begin
          ownsPort[i] = 1'b1;
        end
      end
      errSet[i] = req_valid_i[i] & (!portOk[i] | (isCont[i] & !ownsPort[i]));
    end
    for (int o = 0; o < N_OUT; o++) begin
      if ((state_q[o] == ST_LOCKED) && xfer[o] && isStart[owner_q[o]]) begin
        errSet[owner_q[o]] = 1'b1;
      end
    end
    err_d = err_q | errSet;
  end

  always_comb begin
    for (int o = 0; o < N_OUT; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      rr_d[o]    = rr_q[o];
      cnt_d[o]   = cnt_q[o];
      if (xfer[o]) begin
        if (state_q[o] == ST_IDLE) begin
          if (winType[o] == TY_HEAD) begin
            state_d[o] = ST_LOCKED;
            owner_d[o] = winIdx[o];
          end else begin
            rr_d[o]  = winIdx[o];
            cnt_d[o] = (cnt_q[o] == CNT_MAX) ? cnt_q[o] : cnt_q[o] + CNT_W'(1);
          end
        end else if (winType[o] == TY_TAIL) begin
          state_d[o] = ST_IDLE;
          rr_d[o]    = owner_q[o];
          cnt_d[o]   = (cnt_q[o] == CNT_MAX) ? cnt_q[o] : cnt_q[o] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (arst) begin
      for (int o = 0; o < N_OUT; o++) begin
        state_q[o] <= ST_IDLE;
        owner_q[o] <= '0;
        rr_q[o]    <= RR_RESET;
        cnt_q[o]   <= '0;
      end
      err_q <= '0;
    end else begin
      for (int o = 0; o < N_OUT; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        rr_q[o]    <= rr_d[o];
        cnt_q[o]   <= cnt_d[o];
      end
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: table of single-cycle vectors plus hand-written
// wormhole, error and mid-packet reset sequences, checked through a scoreboard.
module tb_switch_allocator;

  localparam int NI = 5;
  localparam int NO = 5;
  localparam int CW = 3;

  localparam logic [1:0] HD = 2'b00;
  localparam logic [1:0] BD = 2'b01;
  localparam logic [1:0] TL = 2'b10;
  localparam logic [1:0] HT = 2'b11;

  logic           clk = 1'b0;
  logic           arst = 1'b1;
  logic [NI-1:0]  reqValid = '0;
  logic [24:0]    reqPort = '0;
  logic [9:0]     reqType = '0;
  logic [NO-1:0]  outReady = '0;
  logic [24:0]    grant;
  logic [NO-1:0]  outValid;
  logic [NI-1:0]  inReady;
  logic [NO-1:0]  lock;
  logic [NI-1:0]  err;
  logic [NO*CW-1:0] pktCnt;

  switch_allocator #(.N_IN(NI), .N_OUT(NO), .CNT_W(CW)) dut (
    .clk(clk),
    .arst(arst),
    .req_valid_i(reqValid),
    .req_port_i(reqPort),
    .req_type_i(reqType),
    .out_ready_i(outReady),
    .grant_o(grant),
    .out_valid_o(outValid),
    .in_ready_o(inReady),
    .lock_o(lock),
    .err_o(err),
    .pkt_cnt_o(pktCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [39:0] req;
    logic [4:0]  ready;
    logic [24:0] expGrant;
    logic [4:0]  expInReady;
    logic [4:0]  expLock;
    logic [4:0]  expErr;
    int          cntO;
    logic [2:0]  expCnt;
  } vec_t;

  vec_t sbQueue[$];
  vec_t tbl[17];
  int checks = 0;
  int failures = 0;

  // Request word layout: [39:35] valid, [34:10] port slices, [9:0] type slices.
  function automatic logic [39:0] rqRaw(input int i, input logic [4:0] p, input logic [1:0] t);
    logic [39:0] r;
    r = '0;
    r[35+i] = 1'b1;
    r[10+i*5 +: 5] = p;
    r[i*2 +: 2] = t;
    return r;
  endfunction

  function automatic logic [39:0] rq(input int i, input int o, input logic [1:0] t);
    logic [4:0] p;
    p = '0;
    p[o] = 1'b1;
    return rqRaw(i, p, t);
  endfunction

  function automatic logic [24:0] g(input int o, input int i);
    logic [24:0] x;
    x = '0;
    x[o*5+i] = 1'b1;
    return x;
  endfunction

  function automatic logic [4:0] orSlices(input logic [24:0] gr);
    logic [4:0] v;
    for (int o = 0; o < NO; o++) v[o] = |gr[o*5 +: 5];
    return v;
  endfunction

  function automatic vec_t mkVec(input logic rst, input logic [39:0] req, input logic [4:0] ready,
                                 input logic [24:0] eg, input logic [4:0] ei, input logic [4:0] el,
                                 input logic [4:0] ee, input int co, input logic [2:0] ec);
    vec_t v;
    v.rst = rst; v.req = req; v.ready = ready;
    v.expGrant = eg; v.expInReady = ei; v.expLock = el; v.expErr = ee;
    v.cntO = co; v.expCnt = ec;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    arst     = v.rst;
    reqValid = v.req[39:35];
    reqPort  = v.req[34:10];
    reqType  = v.req[9:0];
    outReady = v.ready;
    sbQueue.push_back(v);
  endtask

  task automatic checkVal(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s vec %0d: got %h, want %h", name, id, act, exp);
    end
  endtask

  task automatic checkOutput(input int id);
    vec_t e;
    if (sbQueue.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard vec %0d: got empty queue, want entry", id);
    end else begin
      e = sbQueue.pop_front();
      checkVal("grant", id, 32'(grant), 32'(e.expGrant));
      checkVal("out_valid", id, 32'(outValid), 32'(orSlices(e.expGrant)));
      checkVal("in_ready", id, 32'(inReady), 32'(e.expInReady));
      checkVal("lock", id, 32'(lock), 32'(e.expLock));
      checkVal("err", id, 32'(err), 32'(e.expErr));
      checkVal("pkt_cnt", id, 32'(pktCnt[e.cntO*CW +: CW]), 32'(e.expCnt));
    end
  endtask

  task automatic step(input vec_t v, input int id);
    @(negedge clk);
    applyStimulus(v);
    #2;
    checkOutput(id);
  endtask

  initial begin
    logic [39:0] allHt, rr3;
    allHt = rq(0,0,HT) | rq(1,1,HT) | rq(2,2,HT) | rq(3,3,HT) | rq(4,4,HT);
    rr3   = rq(0,4,HT) | rq(1,4,HT) | rq(3,4,HT);

    // Reset, first grant, single head-tail, round-robin, saturation, backpressure.
    tbl[0]  = mkVec(1'b1, allHt, 5'h1F, '0, '0, '0, '0, 0, 3'd0);
    tbl[1]  = mkVec(1'b1, allHt, 5'h1F, '0, '0, '0, '0, 4, 3'd0);
    tbl[2]  = mkVec(1'b0, rq(0,2,HT) | rq(4,2,HT), 5'h1F, g(2,0), 5'b00001, '0, '0, 2, 3'd0);
    tbl[3]  = mkVec(1'b0, rq(0,2,HT) | rq(4,2,HT), 5'h1F, g(2,4), 5'b10000, '0, '0, 2, 3'd1);
    tbl[4]  = mkVec(1'b0, rq(2,1,HT), 5'h1F, g(1,2), 5'b00100, '0, '0, 2, 3'd2);
    tbl[5]  = mkVec(1'b0, rr3, 5'h1F, g(4,0), 5'b00001, '0, '0, 1, 3'd1);
    tbl[6]  = mkVec(1'b0, rr3, 5'h1F, g(4,1), 5'b00010, '0, '0, 4, 3'd1);
    tbl[7]  = mkVec(1'b0, rr3, 5'h1F, g(4,3), 5'b01000, '0, '0, 4, 3'd2);
    tbl[8]  = mkVec(1'b0, rr3, 5'h1F, g(4,0), 5'b00001, '0, '0, 4, 3'd3);
    tbl[9]  = mkVec(1'b0, rr3, 5'h1F, g(4,1), 5'b00010, '0, '0, 4, 3'd4);
    tbl[10] = mkVec(1'b0, rr3, 5'h1F, g(4,3), 5'b01000, '0, '0, 4, 3'd5);
    tbl[11] = mkVec(1'b0, '0, 5'h1F, '0, '0, '0, '0, 4, 3'd6);
    tbl[12] = mkVec(1'b0, rq(0,4,HT), 5'h1F, g(4,0), 5'b00001, '0, '0, 4, 3'd6);
    tbl[13] = mkVec(1'b0, rq(0,4,HT), 5'h1F, g(4,0), 5'b00001, '0, '0, 4, 3'd7);
    tbl[14] = mkVec(1'b0, '0, 5'h1F, '0, '0, '0, '0, 4, 3'd7);
    tbl[15] = mkVec(1'b0, rq(3,4,HT), 5'b01111, g(4,3), '0, '0, '0, 4, 3'd7);
    tbl[16] = mkVec(1'b0, rq(3,4,HT) | rq(4,4,HT), 5'b01111, g(4,3), '0, '0, '0, 4, 3'd7);

    for (int k = 0; k < 17; k++) step(tbl[k], k);

    // Wormhole on output 0 with two stalled cycles mid-packet.
    step(mkVec(1'b0, rq(1,0,HD) | rq(2,0,HD), 5'h1F, g(0,1), 5'b00010, '0, '0, 0, 3'd0), 100);
    step(mkVec(1'b0, rq(1,0,BD) | rq(2,0,HD), 5'b11110, g(0,1), '0, 5'b00001, '0, 0, 3'd0), 101);
    step(mkVec(1'b0, rq(1,0,BD) | rq(2,0,HD), 5'b11110, g(0,1), '0, 5'b00001, '0, 0, 3'd0), 102);
    step(mkVec(1'b0, rq(1,0,BD) | rq(2,0,HD), 5'h1F, g(0,1), 5'b00010, 5'b00001, '0, 0, 3'd0), 103);
    step(mkVec(1'b0, rq(1,0,BD) | rq(2,0,HD), 5'h1F, g(0,1), 5'b00010, 5'b00001, '0, 0, 3'd0), 104);
    step(mkVec(1'b0, rq(1,0,TL) | rq(2,0,HD), 5'h1F, g(0,1), 5'b00010, 5'b00001, '0, 0, 3'd0), 105);
    step(mkVec(1'b0, rq(2,0,HD), 5'h1F, g(0,2), 5'b00100, '0, '0, 0, 3'd1), 106);
    step(mkVec(1'b0, rq(2,0,TL), 5'h1F, g(0,2), 5'b00100, 5'b00001, '0, 0, 3'd1), 107);
    step(mkVec(1'b0, '0, 5'h1F, '0, '0, '0, '0, 0, 3'd2), 108);

    // Parallel transfers and protocol errors; err_o shows up one cycle later.
    step(mkVec(1'b0, rq(0,1,HT) | rq(3,2,HT), 5'h1F, g(1,0) | g(2,3), 5'b01001, '0, '0, 1, 3'd1), 200);
    step(mkVec(1'b0, rqRaw(4,5'b00011,HT), 5'h1F, '0, '0, '0, '0, 1, 3'd2), 201);
    step(mkVec(1'b0, rqRaw(4,5'b00011,HT) | rq(2,3,BD), 5'h1F, '0, '0, '0, 5'b10000, 2, 3'd3), 202);
    step(mkVec(1'b0, '0, 5'h1F, '0, '0, '0, 5'b10100, 0, 3'd2), 203);
    step(mkVec(1'b0, rq(1,3,HD), 5'h1F, g(3,1), 5'b00010, '0, 5'b10100, 0, 3'd2), 204);
    step(mkVec(1'b0, rq(1,3,HD), 5'h1F, g(3,1), 5'b00010, 5'b01000, 5'b10100, 3, 3'd0), 205);
    step(mkVec(1'b0, rq(1,3,BD) | rq(2,3,HD), 5'h1F, g(3,1), 5'b00010, 5'b01000, 5'b10110, 3, 3'd0), 206);

    // Reset while output 3 is locked to input 1; input 2 wins right after.
    step(mkVec(1'b1, rq(1,3,BD) | rq(2,3,HD), 5'h1F, '0, '0, 5'b01000, 5'b10110, 3, 3'd0), 300);
    step(mkVec(1'b0, rq(2,3,HD), 5'h1F, g(3,2), 5'b00100, '0, '0, 0, 3'd0), 301);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
